// File: rtl/vga_pkg.sv
// Shared definitions for the raster timing generator: default 640x480@60
// timing, output-mode encodings, bar colours and the pipeline stage record.
package vga_pkg;

    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_SOLID = 2'd2,
        MODE_PASS  = 2'd3
    } mode_t;

    // {r,g,b} for the eight bars, left to right
    localparam logic [11:0] BAR_TABLE [8] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'hF0F, 12'h0FF, 12'hFFF, 12'h000
    };

    // One pixel's worth of decoded timing travelling down the delay line.
    // Syncs are carried as "active" flags; polarity is applied at the pins.
    typedef struct packed {
        logic        de;
        logic        hs_act;
        logic        vs_act;
        logic        vb;
        logic        ls;
        logic        fs;
        logic        pass;
        logic [11:0] col;
    } stage_t;

    localparam stage_t STAGE_BLANK = '0;

endpackage

// File: rtl/vga_timing_gen_pattern.sv
// Test-pattern colour generator: colour for the stage-0 pixel, with an
// incremental bar tracker so no divider is needed for the colour bars.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_VIS = DEF_H_VIS,
    parameter int H_TOT = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP,
    parameter int CW    = 11
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CW-1:0] h,
    input  logic [CW-1:0] v,
    input  mode_t         mode,
    input  logic [11:0]   solid_rgb,
    output logic [11:0]   col
);

    localparam int            BAR_W    = H_VIS / 8;
    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);

    logic [CW-1:0] bar_pix;
    logic [2:0]    bar_idx;

    // Follow h: bar_idx is the bar containing the current h, reset at line wrap
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            bar_pix <= '0;
            bar_idx <= '0;
        end else if (en) begin
            if (h == H_LAST) begin
                bar_pix <= '0;
                bar_idx <= '0;
            end else if (bar_pix == BAR_LAST) begin
                bar_pix <= '0;
                // past the last bar we are in blanking; colour is masked anyway
                if (bar_idx != 3'd7) begin
                    bar_idx <= bar_idx + 3'd1;
                end
            end else begin
                bar_pix <= bar_pix + CW'(1);
            end
        end
    end

    // Pattern colour for the current mode; pass-through is resolved at the output
    always_comb begin
        col = 12'h000;
        case (mode)
            MODE_BARS:  col = BAR_TABLE[bar_idx];
            MODE_CHECK: col = (h[5] ^ v[5]) ? 12'hFFF : 12'h000;
            MODE_SOLID: col = solid_rgb;
            default:    col = 12'h000;
        endcase
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-enable stall, renderer
// alignment delay, frame counter and frame-synchronous pattern/pass-through mux.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VIS   = DEF_H_VIS,
    parameter int H_FP    = DEF_H_FP,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BP    = DEF_H_BP,
    parameter int V_VIS   = DEF_V_VIS,
    parameter int V_FP    = DEF_V_FP,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BP    = DEF_V_BP,
    parameter int HS_POL  = 0,
    parameter int VS_POL  = 0,
    parameter int CW      = 11,
    parameter int PIPE    = 0,
    parameter int FRAME_W = 16
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [11:0]        solid_rgb,
    input  logic [11:0]        pix_in,
    output logic [CW-1:0]      h,
    output logic [CW-1:0]      v,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [3:0]         r,
    output logic [3:0]         g,
    output logic [3:0]         b,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOT - 1);
    localparam logic [CW-1:0] H_VIS_C = CW'(H_VIS);
    localparam logic [CW-1:0] V_VIS_C = CW'(V_VIS);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_VIS + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_VIS + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_VIS + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_VIS + V_FP + V_SYNC);
    localparam logic          HS_ON   = (HS_POL != 0);
    localparam logic          VS_ON   = (VS_POL != 0);

    logic [CW-1:0]      h_reg;
    logic [CW-1:0]      v_reg;
    logic [FRAME_W-1:0] frame_cnt_reg;
    mode_t              mode_q;
    logic               h_wrap;
    logic               frame_wrap;

    assign h_wrap     = (h_reg == H_LAST);
    assign frame_wrap = h_wrap && (v_reg == V_LAST);

    // Raster counters, frame counter and frame-synchronous mode latch
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_reg         <= '0;
            v_reg         <= '0;
            frame_cnt_reg <= '0;
            mode_q        <= MODE_BARS;
        end else if (en) begin
            h_reg <= h_wrap ? '0 : h_reg + CW'(1);
            if (h_wrap) begin
                v_reg <= (v_reg == V_LAST) ? '0 : v_reg + CW'(1);
            end
            if (frame_wrap) begin
                frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
                mode_q        <= mode_t'(mode);
            end
        end
    end

    logic [11:0] pat_col;

    vga_pattern_gen #(
        .H_VIS (H_VIS),
        .H_TOT (H_TOT),
        .CW    (CW)
    ) u_pattern (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .en        (en),
        .h         (h_reg),
        .v         (v_reg),
        .mode      (mode_q),
        .solid_rgb (solid_rgb),
        .col       (pat_col)
    );

    stage_t s0;

    // Stage-0 decode of the current counter position
    always_comb begin
        s0        = STAGE_BLANK;
        s0.de     = (h_reg < H_VIS_C) && (v_reg < V_VIS_C);
        s0.hs_act = (h_reg >= HS_BEG) && (h_reg < HS_END);
        s0.vs_act = (v_reg >= VS_BEG) && (v_reg < VS_END);
        s0.vb     = (v_reg >= V_VIS_C);
        s0.ls     = (h_reg == '0);
        s0.fs     = (h_reg == '0) && (v_reg == '0);
        s0.pass   = (mode_q == MODE_PASS);
        s0.col    = pat_col;
    end

    stage_t dly;

    generate
        if (PIPE == 0) begin : g_nopipe
            assign dly = s0;
        end else begin : g_pipe
            stage_t q [PIPE];

            // Alignment delay line matching the renderer latency
            always_ff @(posedge pclk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE; i++) begin
                        q[i] <= STAGE_BLANK;
                    end
                end else if (en) begin
                    q[0] <= s0;
                    for (int i = 1; i < PIPE; i++) begin
                        q[i] <= q[i-1];
                    end
                end
            end

            assign dly = q[PIPE-1];
        end
    endgenerate

    logic        de_reg;
    logic        hs_reg;
    logic        vs_reg;
    logic        vb_reg;
    logic        ls_reg;
    logic        fs_reg;
    logic [11:0] rgb_reg;

    // Output register: pin polarity, colour select, and strobes that drop during a stall
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            de_reg  <= 1'b0;
            hs_reg  <= ~HS_ON;
            vs_reg  <= ~VS_ON;
            vb_reg  <= 1'b0;
            ls_reg  <= 1'b0;
            fs_reg  <= 1'b0;
            rgb_reg <= '0;
        end else if (en) begin
            de_reg <= dly.de;
            hs_reg <= dly.hs_act ? HS_ON : ~HS_ON;
            vs_reg <= dly.vs_act ? VS_ON : ~VS_ON;
            vb_reg <= dly.vb;
            ls_reg <= dly.ls;
            fs_reg <= dly.fs;
            if (!dly.de) begin
                rgb_reg <= '0;
            end else if (dly.pass) begin
                rgb_reg <= pix_in;
            end else begin
                rgb_reg <= dly.col;
            end
        end else begin
            ls_reg <= 1'b0;
            fs_reg <= 1'b0;
        end
    end

    assign h           = h_reg;
    assign v           = v_reg;
    assign hs          = hs_reg;
    assign vs          = vs_reg;
    assign de          = de_reg;
    assign vblank      = vb_reg;
    assign line_start  = ls_reg;
    assign frame_start = fs_reg;
    assign r           = rgb_reg[11:8];
    assign g           = rgb_reg[7:4];
    assign b           = rgb_reg[3:0];
    assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster (80x54 totals,
// PIPE=2, mixed sync polarity, 2-bit frame counter to exercise wrap).
module tb_vga_timing_gen;

    localparam int H_VIS = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_VIS = 48, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int HS_POL = 0, VS_POL = 1;
    localparam int CW = 8, PIPE = 2, FRAME_W = 2;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME_LEN = H_TOT * V_TOT;

    logic               pclk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic [11:0]        solid_rgb = 12'h3A7;
    logic [11:0]        pix_in = 12'h000;
    logic [CW-1:0]      h;
    logic [CW-1:0]      v;
    logic               hs, vs, de;
    logic [3:0]         r, g, b;
    logic               line_start, frame_start, vblank;
    logic [FRAME_W-1:0] frame_cnt;

    vga_timing_gen #(
        .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HS_POL (HS_POL), .VS_POL (VS_POL), .CW (CW), .PIPE (PIPE),
        .FRAME_W (FRAME_W)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode),
        .solid_rgb   (solid_rgb),
        .pix_in      (pix_in),
        .h           (h),
        .v           (v),
        .hs          (hs),
        .vs          (vs),
        .de          (de),
        .r           (r),
        .g           (g),
        .b           (b),
        .line_start  (line_start),
        .frame_start (frame_start),
        .vblank      (vblank),
        .frame_cnt   (frame_cnt)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [CW-1:0] h;
        logic [CW-1:0] v;
        logic          de, hs, vs, vb, ls, fs, pass;
        logic [11:0]   col;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          hm, vm, fcnt;
    logic [1:0]  mode_qm;
    exp_t        pend[$];
    logic [17:0] exp_out;
    logic        check_period = 1'b0;
    int          last_fs = -1;
    logic        count_on = 1'b0;
    int          hs_cnt, vs_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d, model h=%0d v=%0d)",
                     tag, obs, expv, cyc, hm, vm);
        end
    endtask

    function automatic logic [11:0] bar_ref(input int hh);
        case (hh / (H_VIS / 8))
            0: return 12'hF00;
            1: return 12'h0F0;
            2: return 12'h00F;
            3: return 12'hFF0;
            4: return 12'hF0F;
            5: return 12'h0FF;
            6: return 12'hFFF;
            default: return 12'h000;
        endcase
    endfunction

    function automatic exp_t blank_entry();
        exp_t e;
        e.h = '0; e.v = '0;
        e.de = 1'b0; e.vb = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.pass = 1'b0;
        e.hs = (HS_POL == 0);
        e.vs = (VS_POL == 0);
        e.col = 12'h000;
        return e;
    endfunction

    function automatic exp_t make_entry(input int hh, input int vv);
        exp_t e;
        logic hact, vact;
        e.h    = CW'(hh);
        e.v    = CW'(vv);
        e.de   = (hh < H_VIS) && (vv < V_VIS);
        hact   = (hh >= H_VIS + H_FP) && (hh < H_VIS + H_FP + H_SYNC);
        vact   = (vv >= V_VIS + V_FP) && (vv < V_VIS + V_FP + V_SYNC);
        e.hs   = hact ? (HS_POL != 0) : (HS_POL == 0);
        e.vs   = vact ? (VS_POL != 0) : (VS_POL == 0);
        e.vb   = (vv >= V_VIS);
        e.ls   = (hh == 0);
        e.fs   = (hh == 0) && (vv == 0);
        e.pass = (mode_qm == 2'd3);
        case (mode_qm)
            2'd0: e.col = bar_ref(hh);
            2'd1: e.col = ((((hh >> 5) ^ (vv >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
            2'd2: e.col = solid_rgb;
            default: e.col = 12'h000;
        endcase
        return e;
    endfunction

    function automatic logic [17:0] pack(input exp_t e, input logic [11:0] pin);
        logic [11:0] c;
        c = !e.de ? 12'h000 : (e.pass ? pin : e.col);
        return {e.de, e.hs, e.vs, e.vb, e.ls, e.fs, c};
    endfunction

    function automatic logic [17:0] observed();
        return {de, hs, vs, vblank, line_start, frame_start, r, g, b};
    endfunction

    task automatic reset_model();
        hm = 0; vm = 0; fcnt = 0; mode_qm = 2'd0;
        pend.delete();
        for (int i = 0; i < PIPE; i++) pend.push_back(blank_entry());
        exp_out = pack(blank_entry(), 12'h000);
    endtask

    // One clock: push the pixel entering the pipe, pop the one reaching the pins
    task automatic step(input logic en_i);
        exp_t cur, o;
        en = en_i;
        if (en_i) begin
            cur = make_entry(hm, vm);
            pend.push_back(cur);
            o = pend.pop_front();
            pix_in = {o.h[3:0], o.v[3:0], 4'h5};
            exp_out = pack(o, pix_in);
            if (hm == H_TOT - 1 && vm == V_TOT - 1) begin
                mode_qm = mode;
                fcnt = (fcnt + 1) % (1 << FRAME_W);
            end
            if (hm == H_TOT - 1) begin
                hm = 0;
                vm = (vm == V_TOT - 1) ? 0 : vm + 1;
            end else begin
                hm = hm + 1;
            end
        end else begin
            exp_out[13:12] = 2'b00;
        end
        @(posedge pclk);
        #1;
        cyc++;
        chk("out", 32'(observed()), 32'(exp_out));
        chk("h", 32'(h), hm);
        chk("v", 32'(v), vm);
        chk("frame_cnt", 32'(frame_cnt), fcnt);
        if (frame_start && check_period) begin
            if (last_fs >= 0) chk("fs_period", cyc - last_fs, FRAME_LEN);
            last_fs = cyc;
        end
        if (count_on) begin
            if (hs == 1'b0) hs_cnt++;
            if (vs == 1'b1) vs_cnt++;
        end
    endtask

    task automatic run_until(input int hh, input int vv);
        int k;
        k = 0;
        while (!(hm == hh && vm == vv) && k < 2 * FRAME_LEN) begin
            step(1'b1);
            k++;
        end
        chk("run_until", hm * 1000 + vm, hh * 1000 + vv);
    endtask

    initial begin
        int fs_hits;
        int first_k;
        logic [FRAME_W-1:0] fc_before;
        logic [FRAME_W-1:0] fc_diff;
        logic en_pat [10];

        reset_model();
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_out", 32'(observed()), 32'(exp_out));
        chk("rst_h", 32'(h), 0);
        chk("rst_v", 32'(v), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        rst_n = 1'b1;
        $display("phase reset: outputs checked at cycle %0d", cyc);

        // Colour bars, continuous enable: period and sync widths
        mode = 2'd0;
        check_period = 1'b1;
        repeat (FRAME_LEN + 10) step(1'b1);
        hs_cnt = 0; vs_cnt = 0;
        count_on = 1'b1;
        repeat (FRAME_LEN) step(1'b1);
        count_on = 1'b0;
        check_period = 1'b0;
        chk("hs_low_per_frame", hs_cnt, H_SYNC * V_TOT);
        chk("vs_act_per_frame", vs_cnt, V_SYNC * H_TOT);
        $display("phase bars: done at cycle %0d", cyc);

        // Mid-frame switch to checker takes effect only at the next frame
        run_until(0, 10);
        mode = 2'd1;
        repeat (FRAME_LEN + 100) step(1'b1);
        $display("phase checker: done at cycle %0d", cyc);

        mode = 2'd2;
        repeat (FRAME_LEN + 100) step(1'b1);
        $display("phase solid: done at cycle %0d", cyc);

        mode = 2'd3;
        repeat (FRAME_LEN + 100) step(1'b1);
        $display("phase pass-through: done at cycle %0d", cyc);

        // Random stalls with pass-through data
        repeat (FRAME_LEN) step($urandom_range(0, 3) != 0);
        $display("phase random stall: done at cycle %0d", cyc);

        // Stall straddling the frame wrap
        run_until(H_TOT - 1, V_TOT - 1);
        fc_before = frame_cnt;
        step(1'b1);
        en_pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        fs_hits = 0;
        for (int i = 0; i < 10; i++) begin
            step(en_pat[i]);
            if (frame_start) fs_hits++;
        end
        fc_diff = frame_cnt - fc_before;
        chk("fs_pulse_count", fs_hits, 1);
        chk("frame_cnt_inc", 32'(fc_diff), 1);
        $display("phase wrap stall: done at cycle %0d", cyc);

        // Asynchronous reset in the middle of the visible area
        mode = 2'd0;
        run_until(30, 20);
        #3;
        rst_n = 1'b0;
        reset_model();
        #1;
        chk("midrst_out", 32'(observed()), 32'(exp_out));
        chk("midrst_h", 32'(h), 0);
        chk("midrst_v", 32'(v), 0);
        chk("midrst_frame_cnt", 32'(frame_cnt), 0);
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
        first_k = -1;
        for (int k = 1; k <= PIPE + 3; k++) begin
            step(1'b1);
            if (frame_start && first_k < 0) first_k = k;
        end
        chk("fs_after_rst", first_k, PIPE + 1);
        repeat (300) step(1'b1);
        $display("phase mid reset: done at cycle %0d", cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA core: a raster timing generator with configurable H/V timing and sync polarity, and a pixel-clock-enable stall.
- Provides a PIPE-stage alignment delay so hs/vs/de line up with an external renderer's pixel data.
- Provides a frame counter, line/frame strobes and a frame-synchronous test-pattern/pass-through output mux.
- Sits between the pixel-clock PLL and the board VGA DAC pins; h/v drive renderer addressing.

Parameters:
H_VIS, 640, visible pixels per line (multiple of 8)
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_VIS, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, active level of hs (0 = active-low)
VS_POL, 0, active level of vs
CW, 11, h/v counter width (must hold H_TOT-1 and V_TOT-1)
PIPE, 0, renderer latency in cycles (0..3)
FRAME_W, 16, frame counter width

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
en  in  1  pixel enable; 0 stalls the whole block
mode  in  2  0 colour bars, 1 checker, 2 solid, 3 pass-through
solid_rgb  in  12  {r,g,b} colour for mode 2
pix_in  in  12  renderer pixel for mode 3, valid PIPE cycles after its h/v
h  out  CW  current column counter (stage 0)
v  out  CW  current line counter (stage 0)
hs  out  1  horizontal sync, aligned to r/g/b
vs  out  1  vertical sync, aligned to r/g/b
de  out  1  visible-area data enable, aligned to r/g/b
r, g, b  out  4 each  pixel colour
line_start  out  1  one-cycle pulse at output of pixel h=0
frame_start  out  1  one-cycle pulse at output of pixel (0,0)
vblank  out  1  v >= V_VIS, aligned to r/g/b
frame_cnt  out  FRAME_W  completed-frame count

Behaviour:
Reset values (rst_n=0, async):
- h=v=0, de=0, r=g=b=0.
- hs=~HS_POL, vs=~VS_POL.
- line_start=frame_start=0, vblank=0, frame_cnt=0.
- All pipeline stages cleared to the same blank/inactive values; mode_q=0.

Totals:
- H_TOT = H_VIS+H_FP+H_SYNC+H_BP; V_TOT likewise (defaults 800 and 525).

Counters (advance only when en=1):
- h increments each enabled cycle.
- At h=H_TOT-1: h<=0, and v<=v+1, or v<=0 if v=V_TOT-1.
- On the (H_TOT-1, V_TOT-1) wrap: frame_cnt increments, modulo 2^FRAME_W.

Raw stage-0 decodes from h/v:
- de = h<H_VIS && v<V_VIS.
- hs active for H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC; vs likewise on v.
- line_start flag = h==0; frame_start flag = h==0 && v==0.
- Internal pattern colour is also decoded at stage 0.

Latency:
- Raw decodes pass through PIPE enabled delay stages, then one output register.
- Outputs for counter value (h,v) appear exactly PIPE+1 enabled cycles after h/v show it.
- pix_in is sampled into the output register in the same cycle as the delayed de for its pixel.

Output colour:
- de=0: r/g/b = 0 in all modes.
- Otherwise selected by mode_q:
  - Mode 0: 8 vertical bars, each H_VIS/8 wide, left to right red, green, blue, yellow, magenta, cyan, white, black (components F or 0). Use an incremental bar counter, no divider.
  - Mode 1: white when h[5]^v[5], else black.
  - Mode 2: solid_rgb.
  - Mode 3: pix_in.

Mode latch:
- mode_q <= mode only on the enabled cycle where h=H_TOT-1 and v=V_TOT-1.
- A mid-frame mode change never tears the frame.

Stall (en=0):
- Counters, pipeline, output registers and frame_cnt hold their values.
- line_start and frame_start are forced 0; pulses never stretch across a stall.

Mid-operation reset:
- Asynchronous return to reset values.
- After release, the first enabled cycle shows h=1, and frame_start fires PIPE+1 enabled cycles after release.

Decomposition:
- Shared package vga_pkg holds:
  - default 640x480@60 timing constants;
  - mode encodings (MODE_BARS, MODE_CHECK, MODE_SOLID, MODE_PASS);
  - 12-bit bar colour table.
- One natural sub-module: vga_pattern_gen. It takes stage-0 h/v/mode and produces the 12-bit pattern colour combinationally, with the bar counter inside.

Test Plan:
- Defaults, en=1 → hs low for exactly 96 cycles per 800-cycle line, falling at the output of h=656; vs low for 2 lines (1600 cycles) starting at line 490; frame_start period 420000 cycles.
- Mode 0, PIPE=0 → output pixel h=0..79 is F00, h=80 is 0F0, h=560..639 is 000; de=0 and rgb=000 at h=640..799.
- PIPE=2, mode 3, pix_in = {h[3:0],v[3:0],4'h5} driven 2 cycles late → every visible output equals the expected value for its pixel; de/hs edges shifted 3 cycles from h/v.
- en toggled 1,0,0,1 across h=799/v=524 → frame_start high for exactly one cycle; frame_cnt increments by 1; h/v hold during en=0.
- mode changed 0→1 at v=100 → bars until frame end; checker from the next frame's pixel (0,0) (h=32,v=0 white).
- rst_n pulsed low at h=300,v=200 → all outputs at reset values immediately; frame_cnt=0; frame_start reasserts 1 cycle after release for PIPE=0.
